// File: rtl/aes_pkg.sv
// Shared definitions for the sequential AES key-schedule engine:
// mode encodings, FSM states, per-mode schedule geometry and GF(2^8) xtime.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] round_key_t;

    // Key-size selector encoding
    localparam logic [1:0] MODE_128     = 2'b00;
    localparam logic [1:0] MODE_192     = 2'b01;
    localparam logic [1:0] MODE_256     = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    // Width of the schedule word counter (holds 0..60 inclusive)
    localparam int WCNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Key length in 32-bit words
    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        case (mode)
            MODE_128: nk_of = 4'd4;
            MODE_192: nk_of = 4'd6;
            MODE_256: nk_of = 4'd8;
            default:  nk_of = 4'd8;
        endcase
    endfunction

    // Number of cipher rounds
    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_128: nr_of = 4'd10;
            MODE_192: nr_of = 4'd12;
            MODE_256: nr_of = 4'd14;
            default:  nr_of = 4'd14;
        endcase
    endfunction

    // Total schedule words, 4*(Nr+1)
    function automatic logic [WCNT_W-1:0] total_of(input logic [1:0] mode);
        case (mode)
            MODE_128: total_of = 7'd44;
            MODE_192: total_of = 7'd52;
            MODE_256: total_of = 7'd60;
            default:  total_of = 7'd60;
        endcase
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel AES S-box lookups on a 32-bit word (combinational).
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t i_word,
    output word_t o_word
);

    // S-box flattened MSB-first: entry 0 sits in bits [2047:2040]
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            logic [7:0] w_in_byte;
            assign w_in_byte = i_word[8*gi +: 8];
            // Entry x lives at bit offset (255-x)*8, i.e. {~x, 3'b000}
            assign o_word[8*gi +: 8] = SBOX_FLAT[{~w_in_byte, 3'b000} +: 8];
        end
    endgenerate

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key expansion: one schedule word per clock into
// a word buffer, finished schedule read out through a registered round-key port.
// Bit order: the key's byte 0 occupies i_key[255:248]; in o_rk, the word
// w[4*idx] occupies o_rk[127:96].
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int MAX_WORDS = 60,
    parameter int RK_IDX_W  = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [1:0]          i_mode,
    input  logic [255:0]        i_key,
    output logic                o_ready,
    output logic                o_done,
    output logic                o_err,
    output logic [3:0]          o_nr,
    input  logic [RK_IDX_W-1:0] i_rk_idx,
    output logic [127:0]        o_rk,
    output logic                o_rk_valid
);

    localparam int AW = $clog2(MAX_WORDS);
    localparam int RW = RK_IDX_W + 2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             r_state;
    logic               r_ready;
    logic               r_done;
    logic               r_err;
    logic [3:0]         r_nr;
    logic [1:0]         r_mode;
    logic [WCNT_W-1:0]  r_i;
    logic [2:0]         r_phase;
    logic [7:0]         r_rcon;
    // Last eight generated words, r_win[0] newest: supplies w[i-1] and w[i-Nk]
    word_t              r_win [8];
    word_t              r_buf [MAX_WORDS];
    logic [127:0]       r_rk;
    logic               r_rk_valid;

    // ------------------------------------------------------------------
    // Start decode and key loading
    // ------------------------------------------------------------------
    logic               w_start_ok;
    logic               w_start_bad;
    logic [3:0]         w_in_nk;
    word_t              w_key_word  [8];
    word_t              w_win_load  [8];
    logic [2:0]         w_load_sel  [8];

    assign w_start_ok  = i_start && r_ready && (i_mode != MODE_ILLEGAL);
    assign w_start_bad = i_start && r_ready && (i_mode == MODE_ILLEGAL);
    assign w_in_nk     = nk_of(i_mode);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_key
            assign w_key_word[gi] = i_key[255-32*gi -: 32];
            // Window is newest-first, so slot gi takes key word Nk-1-gi
            assign w_load_sel[gi] = 3'(w_in_nk - 4'(gi) - 4'd1);
            assign w_win_load[gi] = (4'(gi) < w_in_nk) ? w_key_word[w_load_sel[gi]] : '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Expansion datapath
    // ------------------------------------------------------------------
    logic [3:0]         w_nk;
    logic [2:0]         w_nk_m1;
    logic [WCNT_W-1:0]  w_total;
    word_t              w_prev;
    word_t              w_old;
    word_t              w_rot;
    word_t              w_sub_in;
    word_t              w_sub_out;
    word_t              w_temp;
    word_t              w_new;
    logic               w_phase_zero;
    logic               w_phase_mid;
    logic               w_last_phase;
    logic               w_expand_write;

    assign w_nk         = nk_of(r_mode);
    assign w_nk_m1      = 3'(w_nk - 4'd1);
    assign w_total      = total_of(r_mode);
    assign w_prev       = r_win[0];
    assign w_old        = r_win[w_nk_m1];
    assign w_rot        = {w_prev[23:0], w_prev[31:24]};
    assign w_phase_zero = (r_phase == 3'd0);
    assign w_phase_mid  = (w_nk == 4'd8) && (r_phase == 3'd4);
    assign w_last_phase = (r_phase == w_nk_m1);
    assign w_sub_in     = w_phase_zero ? w_rot : w_prev;
    assign w_expand_write = (r_state == ST_EXPAND) && (r_i != w_total);

    // One S-box bank serves both the phase-0 and the AES-256 phase-4 SubWord
    aes_sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    // Select the temp word feeding the xor with w[i-Nk]
    always_comb begin
        w_temp = w_prev;
        if (w_phase_zero) begin
            w_temp = w_sub_out ^ {r_rcon, 24'h000000};
        end else if (w_phase_mid) begin
            w_temp = w_sub_out;
        end
    end

    assign w_new = w_old ^ w_temp;

    // Control FSM: IDLE -> EXPAND -> DONE, with registered status outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_nr    <= 4'd0;
            r_mode  <= MODE_128;
            r_i     <= '0;
            r_phase <= 3'd0;
            r_rcon  <= 8'h00;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_state <= ST_EXPAND;
                        r_ready <= 1'b0;
                        r_done  <= 1'b0;
                        r_mode  <= i_mode;
                        r_nr    <= nr_of(i_mode);
                        r_i     <= WCNT_W'(w_in_nk);
                        r_phase <= 3'd0;
                        r_rcon  <= 8'h01;
                    end else if (w_start_bad) begin
                        r_err <= 1'b1;
                    end
                end
                ST_EXPAND: begin
                    if (r_i == w_total) begin
                        // Final word was written on the previous edge
                        r_state <= ST_DONE;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_i <= r_i + 1'b1;
                        if (w_last_phase) begin
                            r_phase <= 3'd0;
                            r_rcon  <= xtime(r_rcon);
                        end else begin
                            r_phase <= r_phase + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Sliding window of recent words: load the key, then shift in each new word
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < 8; k++) begin
                r_win[k] <= '0;
            end
        end else if (w_start_ok) begin
            for (int k = 0; k < 8; k++) begin
                r_win[k] <= w_win_load[k];
            end
        end else if (w_expand_write) begin
            r_win[0] <= w_new;
            for (int k = 1; k < 8; k++) begin
                r_win[k] <= r_win[k-1];
            end
        end
    end

    // Schedule buffer writes (key words on start, one word per expand cycle)
    always_ff @(posedge i_clk) begin
        if (w_start_ok) begin
            for (int j = 0; j < 8; j++) begin
                if (4'(j) < w_in_nk) begin
                    r_buf[j] <= w_key_word[j];
                end
            end
        end else if (w_expand_write) begin
            r_buf[r_i[AW-1:0]] <= w_new;
        end
    end

    // ------------------------------------------------------------------
    // Round-key read port
    // ------------------------------------------------------------------
    logic               w_idx_ok;
    logic               w_rd_ok;
    logic [RW-1:0]      w_rd_base;
    word_t              w_rd_word [4];
    round_key_t         w_rd_key;

    assign w_idx_ok  = (i_rk_idx <= RK_IDX_W'(r_nr));
    // A start accepted this edge retires the old schedule immediately
    assign w_rd_ok   = r_done && w_idx_ok && !w_start_ok;
    assign w_rd_base = w_idx_ok ? {i_rk_idx, 2'b00} : '0;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd
            assign w_rd_word[gi] = r_buf[AW'(w_rd_base + RW'(gi))];
        end
    endgenerate

    assign w_rd_key = {w_rd_word[0], w_rd_word[1], w_rd_word[2], w_rd_word[3]};

    // Registered round-key output, zeroed whenever the index is not readable
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rk       <= '0;
            r_rk_valid <= 1'b0;
        end else if (w_rd_ok) begin
            r_rk       <= w_rd_key;
            r_rk_valid <= 1'b1;
        end else begin
            r_rk       <= '0;
            r_rk_valid <= 1'b0;
        end
    end

    assign o_ready    = r_ready;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_nr       = r_nr;
    assign o_rk       = r_rk;
    assign o_rk_valid = r_rk_valid;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: FIPS-197 vectors, control corner
// cases and random keys checked against a textbook key-expansion model.
module tb_aes_key_expand_seq;

    logic         clk;
    logic         i_reset;
    logic         i_start;
    logic [1:0]   i_mode;
    logic [255:0] i_key;
    logic         o_ready;
    logic         o_done;
    logic         o_err;
    logic [3:0]   o_nr;
    logic [3:0]   i_rk_idx;
    logic [127:0] o_rk;
    logic         o_rk_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  m_sbox [256];
    logic [31:0] m_w    [60];
    int          m_nk;
    int          m_nr;
    int          m_t;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_expand_seq #(
        .MAX_WORDS (60),
        .RK_IDX_W  (4)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_mode     (i_mode),
        .i_key      (i_key),
        .o_ready    (o_ready),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_nr       (o_nr),
        .i_rk_idx   (i_rk_idx),
        .o_rk       (o_rk),
        .o_rk_valid (o_rk_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_xt(input logic [7:0] b);
        logic [8:0] d;
        d = {1'b0, b} * 9'd2;
        if (d >= 9'd256) d = d ^ 9'h11b;
        return d[7:0];
    endfunction

    function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p = p ^ x;
            x = m_xt(x);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse then affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (m_gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            m_sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] m_subw(input logic [31:0] w);
        return {m_sbox[w[31:24]], m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]]};
    endfunction

    // FIPS-197 KeyExpansion written with i mod Nk and Rcon[i/Nk]
    task automatic model_expand(input logic [1:0] m, input logic [255:0] k);
        logic [31:0] temp;
        logic [7:0]  rc;
        m_nk = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
        m_nr = m_nk + 6;
        m_t  = 4 * (m_nr + 1);
        for (int j = 0; j < m_nk; j++) m_w[j] = k[255-32*j -: 32];
        for (int j = m_nk; j < m_t; j++) begin
            temp = m_w[j-1];
            if (j % m_nk == 0) begin
                rc = 8'h01;
                for (int r = 1; r < j / m_nk; r++) rc = m_xt(rc);
                temp = m_subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
            end else if (m_nk > 6 && j % m_nk == 4) begin
                temp = m_subw(temp);
            end
            m_w[j] = m_w[j-m_nk] ^ temp;
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int n = 0; n < 8; n++) r[32*n +: 32] = $urandom();
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic start_op(input logic [1:0] m, input logic [255:0] k);
        i_mode  = m;
        i_key   = k;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // Count edges until done; optionally poke a stray start at cycle 'poke'
    task automatic wait_done(input int poke, output int cyc);
        cyc = 0;
        while (!o_done && cyc < 200) begin
            if (cyc == poke) begin
                i_start = 1'b1;
                i_mode  = 2'b10;
                i_key   = rand256();
            end else begin
                i_start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_start = 1'b0;
        chk("done_seen", {127'h0, o_done}, 128'h1);
    endtask

    task automatic read_rk(input int idx, input logic [127:0] exp, input logic exp_v, input string tag);
        i_rk_idx = 4'(idx);
        @(posedge clk); #1;
        chk(tag, o_rk, exp);
        chk({tag, "_v"}, {127'h0, o_rk_valid}, {127'h0, exp_v});
    endtask

    task automatic sweep(input logic [1:0] m, input logic [255:0] k, input string tag);
        logic [127:0] exp;
        model_expand(m, k);
        for (int idx = 0; idx < 16; idx++) begin
            if (idx <= m_nr) exp = {m_w[4*idx], m_w[4*idx+1], m_w[4*idx+2], m_w[4*idx+3]};
            else             exp = '0;
            read_rk(idx, exp, idx <= m_nr, $sformatf("%s_rk%0d", tag, idx));
        end
    endtask

    task automatic do_expand(input logic [1:0] m, input logic [255:0] k, input int poke, input string tag);
        int cyc;
        start_op(m, k);
        wait_done(poke, cyc);
        model_expand(m, k);
        chk({tag, "_lat"}, 128'(cyc), 128'(m_t - m_nk + 1));
        chk({tag, "_nr"}, {124'h0, o_nr}, 128'(m_nr));
        chk({tag, "_ready"}, {127'h0, o_ready}, 128'h1);
        $display("expand %s mode=%0d cycles=%0d nr=%0d", tag, m, cyc, o_nr);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        logic [1:0]   rm;
        logic [255:0] rk;

        i_reset  = 1'b1;
        i_start  = 1'b0;
        i_mode   = 2'b00;
        i_key    = '0;
        i_rk_idx = 4'd0;
        build_sbox();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {127'h0, o_ready}, 128'h1);
        chk("rst_done", {127'h0, o_done}, 128'h0);
        chk("rst_err", {127'h0, o_err}, 128'h0);
        chk("rst_nr", {124'h0, o_nr}, 128'h0);
        chk("rst_rk", o_rk, 128'h0);
        chk("rst_rkv", {127'h0, o_rk_valid}, 128'h0);
        i_reset = 1'b0;

        read_rk(0, 128'h0, 1'b0, "idle_rk0");
        // Illegal mode from IDLE
        start_op(2'b11, rand256());
        chk("idle_err", {127'h0, o_err}, 128'h1);
        chk("idle_err_ready", {127'h0, o_ready}, 128'h1);

        // AES-128 FIPS-197 A.1
        do_expand(2'b00, KEY128, -1, "a128");
        read_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, "a128_kat10");
        read_rk(0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, "a128_kat0");
        sweep(2'b00, KEY128, "a128");

        // AES-192 FIPS-197 A.2
        do_expand(2'b01, KEY192, -1, "a192");
        read_rk(12, 128'he98ba06f448c773c8ecc720401002202, 1'b1, "a192_kat12");
        read_rk(13, 128'h0, 1'b0, "a192_kat13");
        sweep(2'b01, KEY192, "a192");

        // AES-256 FIPS-197 A.3
        do_expand(2'b10, KEY256, -1, "a256");
        read_rk(14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1, "a256_kat14");
        sweep(2'b10, KEY256, "a256");

        // Stray start mid-expansion is ignored
        do_expand(2'b00, KEY128, 10, "poke");
        read_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, "poke_kat10");

        // Illegal mode from DONE: err pulse, schedule kept
        start_op(2'b11, rand256());
        chk("done_err", {127'h0, o_err}, 128'h1);
        chk("done_err_done", {127'h0, o_done}, 128'h1);
        @(posedge clk); #1;
        chk("done_err_clr", {127'h0, o_err}, 128'h0);
        read_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, "done_err_kat10");

        // Reset 20 cycles into an AES-256 expansion
        start_op(2'b10, KEY256);
        repeat (20) begin
            @(posedge clk); #1;
        end
        i_reset = 1'b1;
        #1;
        chk("mid_rst_ready", {127'h0, o_ready}, 128'h1);
        chk("mid_rst_done", {127'h0, o_done}, 128'h0);
        chk("mid_rst_rkv", {127'h0, o_rk_valid}, 128'h0);
        chk("mid_rst_nr", {124'h0, o_nr}, 128'h0);
        @(posedge clk); #1;
        i_reset = 1'b0;
        do_expand(2'b00, KEY128, -1, "after_rst");
        read_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, "after_rst_kat10");

        // Back-to-back: start AES-192 in the cycle AES-256 done rises
        do_expand(2'b10, KEY256, -1, "b2b_256");
        start_op(2'b01, KEY192);
        chk("b2b_done_drop", {127'h0, o_done}, 128'h0);
        chk("b2b_rkv_drop", {127'h0, o_rk_valid}, 128'h0);
        wait_done(-1, cyc);
        chk("b2b_192_lat", 128'(cyc), 128'd47);
        $display("expand b2b_192 mode=1 cycles=%0d nr=%0d", cyc, o_nr);
        read_rk(12, 128'he98ba06f448c773c8ecc720401002202, 1'b1, "b2b_kat12");

        // Random keys and modes against the model
        for (int n = 0; n < 6; n++) begin
            rm = 2'($urandom_range(0, 2));
            rk = rand256();
            do_expand(rm, rk, -1, $sformatf("rnd%0d", n));
            sweep(rm, rk, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
Sequential AES key-schedule engine supporting AES-128, AES-192 and AES-256, selected per operation.
- Generates one 32-bit schedule word per clock into an internal word buffer.
- Exposes the finished schedule through a registered round-key read port.
- Sits between the key register interface and the round/cipher datapath, replacing the fixed AES-128 combinational key expansion.

Parameters:
MAX_WORDS, 60, depth of the word buffer (Nb*(Nr+1) for AES-256); must be ≥60.
RK_IDX_W, 4, width of the round-key index (covers rounds 0..14).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a new expansion; sampled only when ready=1.
mode  input  2  key size: 00=128, 01=192, 10=256, 11=illegal.
key  input  256  cipher key, bit 0 = MSB of byte 0; AES-128 uses key[0:127], AES-192 uses key[0:191], rest ignored.
ready  output  1  high when start will be accepted (state IDLE or DONE).
done  output  1  high from schedule completion until the next accepted start.
err  output  1  one-cycle pulse when start is presented with mode=11.
nr  output  4  round count of the current schedule (10/12/14); 0 after reset.
rk_idx  input  RK_IDX_W  round-key index to read.
rk  output  128  round key rk_idx = words w[4*idx]..w[4*idx+3], w[4*idx] in rk[0:31].
rk_valid  output  1  high one cycle after a read when done=1 and rk_idx≤nr.

Behaviour:
- Reset values: state=IDLE; ready=1, done=0, err=0, nr=0, rk=0, rk_valid=0. The buffer is not reset.
- Nk=4/6/8 and total words T=44/52/60 for mode 00/01/10.
- FSM has three states: IDLE, EXPAND, DONE.
- IDLE/DONE + start + legal mode:
  - On the same edge, latch mode and write w[0..Nk-1] from key.
  - Set i=Nk, phase=0, rcon=0x01; done←0, nr←Nr.
  - Go to EXPAND.
- IDLE/DONE + start + mode=11:
  - Stay in the current state; err=1 for one cycle.
  - done and buffer are unchanged.
- EXPAND, each cycle:
  - temp=w[i-1], computed as follows:
    - phase==0: SubWord(RotWord(temp)) xor {rcon,24'h0}.
    - Nk==8 and phase==4: SubWord(temp).
    - Otherwise temp is used unchanged.
  - Write w[i]=w[i-Nk] xor temp; i++.
  - phase wraps at Nk-1 back to 0.
  - On wrap to 0, rcon←xtime(rcon), reduced with 0x1B.
- No division or modulo in RTL: phase counter plus rcon register only.
- Last write i=T-1 → DONE on the next edge; done=1 and ready=1 in the same cycle.
- Expansion latency, start edge to done high: T-Nk+1 cycles = 41/47/53.
- start during EXPAND is ignored (ready=0). No abort path; only reset aborts.
- Read port is registered, 1-cycle latency, always active:
  - rk←buffer words 4*idx..4*idx+3.
  - When idx>nr or done=0: rk←0 and rk_valid=0.
  - Reads during EXPAND return 0.
- Reset mid-EXPAND: immediate return to IDLE; done=0, nr=0, rk=0, rk_valid=0. Stale buffer content is never visible because done=0.
- A new start from DONE clears done on its edge. Round keys of the previous schedule are unreadable from that edge on.

Decomposition:
- Shared package aes_pkg:
  - mode encoding constants;
  - NK/NR/TOTAL_WORDS lookup functions by mode;
  - xtime function;
  - word_t (32-bit) and round_key_t (128-bit) typedefs.
- One sub-module, aes_sub_word: four combinational S-box lookups on a 32-bit word, instantiated once and shared by both SubWord cases.
- RotWord is plain wiring and needs no module.

Test Plan:
- AES-128 (FIPS-197 A.1), key 2b7e151628aed2a6abf7158809cf4f3c → done 41 cycles after start; rk_idx=10 → rk=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_valid=1; rk_idx=0 → key echoed.
- AES-192 (A.2), key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → done after 47 cycles, nr=12; rk_idx=12 → e98ba06f448c773c8ecc720401002202; rk_idx=13 → rk=0, rk_valid=0.
- AES-256 (A.3), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → done after 53 cycles, nr=14; rk_idx=14 → fe4890d1e6188d0b046df344706c631e (exercises the phase==4 SubWord).
- start pulsed mid-EXPAND with a different key → ignored; final AES-128 result unchanged. start with mode=11 from DONE → err pulse, done stays 1, keys unchanged.
- Assert reset at cycle 20 of an AES-256 expansion → ready=1, done=0, rk_valid=0 immediately. Restart with AES-128 vector → correct result after 41 cycles.
- Back-to-back: AES-256 done, then start AES-192 the same cycle done rises → done drops on that edge; AES-192 result correct after 47 cycles.
